// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the register-file writeback path.
//   DATA_WIDTH / ADDR_WIDTH : default register width and register index width
//   wb_state_t              : writeback FSM states (IDLE, MUL_HI)
//   REQ_ALU/REQ_LOAD/REQ_MUL: bit positions of each requester in valid/grant
//                             vectors
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;

  // Number of writeback sources sharing the port.
  localparam int NUM_REQ = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MUL  = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MUL_HI = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_priority_select.sv
// -----------------------------------------------------------------------------
// wb_priority_select
// Combinational priority picker for the writeback port.
// Ports:
//   valid_i        : per-requester valid (bit positions REQ_ALU/LOAD/MUL),
//                    already masked to zero by the caller when no grant may
//                    be issued
//   load_starved_i : load has lost STARVE_LIMIT consecutive cycles
//   mul_starved_i  : multiplier has lost STARVE_LIMIT consecutive cycles
//   grant_o        : one-hot (or zero) grant vector
// Order: starved Mul > starved Load > ALU > Load > Mul.
// -----------------------------------------------------------------------------
module wb_priority_select
  import cpu_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               load_starved_i,
  input  logic               mul_starved_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    // A starved requester only outranks others while it is actually asking;
    // a stale saturated counter must not steal the port from a live request.
    if (valid_i[REQ_MUL] && mul_starved_i) begin
      grant_o[REQ_MUL] = 1'b1;
    end else if (valid_i[REQ_LOAD] && load_starved_i) begin
      grant_o[REQ_LOAD] = 1'b1;
    end else if (valid_i[REQ_ALU]) begin
      grant_o[REQ_ALU] = 1'b1;
    end else if (valid_i[REQ_LOAD]) begin
      grant_o[REQ_LOAD] = 1'b1;
    end else if (valid_i[REQ_MUL]) begin
      grant_o[REQ_MUL] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port among the ALU, the load unit and
// the multiplier. A multiplier result is twice the register width and goes out
// as two back-to-back beats: low half to MulRD, high half to MulRD+1 (wrapping).
//
// Ports:
//   Clock, Reset                 : rising-edge clock, async active-high reset
//   AluValid/AluRD/AluData       : ALU writeback request
//   AluReady                     : ALU granted this cycle (combinational)
//   LoadValid/LoadRD/LoadData    : load writeback request
//   LoadReady                    : load granted this cycle (combinational)
//   MulValid/MulRD/MulResult     : multiplier writeback request (2*DATA_WIDTH)
//   MulReady                     : multiplier granted; result captured
//   RegWrite/RD/WriteData        : registered write port to the register file
//   Busy                         : high while the high-half beat is on the port
//
// A grant in cycle N appears on RegWrite/RD/WriteData in cycle N+1, so writes
// leave in exactly the order they were granted.
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,

  input  logic                    AluValid,
  input  logic [ADDR_WIDTH-1:0]   AluRD,
  input  logic [DATA_WIDTH-1:0]   AluData,
  output logic                    AluReady,

  input  logic                    LoadValid,
  input  logic [ADDR_WIDTH-1:0]   LoadRD,
  input  logic [DATA_WIDTH-1:0]   LoadData,
  output logic                    LoadReady,

  input  logic                    MulValid,
  input  logic [ADDR_WIDTH-1:0]   MulRD,
  input  logic [2*DATA_WIDTH-1:0] MulResult,
  output logic                    MulReady,

  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   RD,
  output logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    Busy
);

  // Counter wide enough to hold STARVE_LIMIT itself.
  localparam int WAIT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_state_t               state_q, state_d;
  logic [WAIT_W-1:0]       load_wait_q, load_wait_d;
  logic [WAIT_W-1:0]       mul_wait_q, mul_wait_d;
  logic [DATA_WIDTH-1:0]   hi_data_q, hi_data_d;
  logic [ADDR_WIDTH-1:0]   hi_rd_q, hi_rd_d;
  logic                    reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      grant;
  logic                    load_starved;
  logic                    mul_starved;

  // Next starvation count: clear on grant or when not requesting, otherwise
  // count lost cycles up to the limit and hold there.
  function automatic logic [WAIT_W-1:0] next_wait(
    input logic              valid,
    input logic              granted,
    input logic [WAIT_W-1:0] cnt
  );
    if (!valid || granted) begin
      return '0;
    end else if (cnt == WAIT_MAX) begin
      return cnt;
    end else begin
      return cnt + 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // No request can win while the high half is pending, which is what keeps a
  // multiplier sequence from being split by another write.
  always_comb begin
    req_valid           = '0;
    req_valid[REQ_ALU]  = AluValid  && (state_q == IDLE);
    req_valid[REQ_LOAD] = LoadValid && (state_q == IDLE);
    req_valid[REQ_MUL]  = MulValid  && (state_q == IDLE);
  end

  assign load_starved = (load_wait_q == WAIT_MAX);
  assign mul_starved  = (mul_wait_q == WAIT_MAX);

  wb_priority_select u_select (
    .valid_i        (req_valid),
    .load_starved_i (load_starved),
    .mul_starved_i  (mul_starved),
    .grant_o        (grant)
  );

  assign AluReady  = grant[REQ_ALU];
  assign LoadReady = grant[REQ_LOAD];
  assign MulReady  = grant[REQ_MUL];

  // ---------------------------------------------------------------------------
  // FSM and write-port next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    hi_data_d   = hi_data_q;
    hi_rd_d     = hi_rd_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant[REQ_ALU]) begin
          reg_write_d = 1'b1;
          rd_d        = AluRD;
          wdata_d     = AluData;
        end else if (grant[REQ_LOAD]) begin
          reg_write_d = 1'b1;
          rd_d        = LoadRD;
          wdata_d     = LoadData;
        end else if (grant[REQ_MUL]) begin
          reg_write_d = 1'b1;
          rd_d        = MulRD;
          wdata_d     = MulResult[DATA_WIDTH-1:0];
          // Capture the high half now; the producer is free to move on once
          // MulReady has been seen. The index wraps naturally at ADDR_WIDTH.
          hi_data_d   = MulResult[2*DATA_WIDTH-1:DATA_WIDTH];
          hi_rd_d     = MulRD + ADDR_WIDTH'(1);
          state_d     = MUL_HI;
        end
      end
      MUL_HI: begin
        reg_write_d = 1'b1;
        rd_d        = hi_rd_q;
        wdata_d     = hi_data_q;
        // Busy is registered with the port so it frames the high-half beat
        // itself rather than the cycle in which that beat is being prepared.
        busy_d      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_wait_d = next_wait(LoadValid, grant[REQ_LOAD], load_wait_q);
  assign mul_wait_d  = next_wait(MulValid,  grant[REQ_MUL],  mul_wait_q);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset drops state to IDLE, which abandons any captured high half.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      load_wait_q <= '0;
      mul_wait_q  <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_wait_q <= load_wait_d;
      mul_wait_q  <= mul_wait_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  // High-half holding registers are only consumed in MUL_HI, which is always
  // entered through a capture, so they need no reset.
  always_ff @(posedge Clock) begin
    hi_data_q <= hi_data_d;
    hi_rd_q   <= hi_rd_d;
  end

  assign RegWrite  = reg_write_q;
  assign RD        = rd_q;
  assign WriteData = wdata_q;
  assign Busy      = busy_q;

endmodule
